multiplexador_param: RTL and testbench
======================================

MULTIPLEXADOR_PARAM -- requirements
Module: multiplexador_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter SEL_W, default 2, select width; SHALL equal max(1, clog2(CHANNELS)).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port entrada, input, CHANNELS*WIDTH, channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port entrada_valid, input, CHANNELS, per-channel valid.
REQ-008 SHALL have port entrada_ready, output, CHANNELS, per-channel ready; combinational.
REQ-009 SHALL have port set, input, SEL_W, channel select used in fixed mode.
REQ-010 SHALL have port modo, input, 1, 0 = fixed select, 1 = round-robin.
REQ-011 SHALL have port saidaM, output, WIDTH, registered output data.
REQ-012 SHALL have port saida_valid, output, 1, saidaM holds an untaken word.
REQ-013 SHALL have port saida_ready, input, 1, downstream accepts the word.
REQ-014 SHALL have port saida_canal, output, SEL_W, index of the channel that supplied saidaM.

Function
REQ-015 SHALL define load = !saida_valid || saida_ready (output register free or draining this cycle).
REQ-016 SHALL, in fixed mode, grant channel set when entrada_valid[set]=1; otherwise grant nothing.
REQ-017 SHALL, in fixed mode with set >= CHANNELS, grant nothing and assert no entrada_ready bit.
REQ-018 SHALL, in round-robin mode, grant the first channel with entrada_valid=1, searching upward from pointer ptr and wrapping from CHANNELS-1 to 0.
REQ-019 SHALL drive entrada_ready[i]=1 only when load=1 and channel i is granted; at most one bit set per cycle.
REQ-020 SHALL consider an input transfer to occur when entrada_valid[i] && entrada_ready[i].
REQ-021 SHALL, on an input transfer at posedge clk, load saidaM with channel data, saida_canal with i, and set saida_valid=1: latency one cycle.
REQ-022 SHALL, when load=1 with no grant, clear saida_valid; saidaM and saida_canal keep their last values.
REQ-023 SHALL hold saidaM, saida_canal and saida_valid stable while saida_valid=1 and saida_ready=0.
REQ-024 SHALL sustain one transfer per cycle when saida_ready stays 1 (simultaneous drain and load).
REQ-025 SHALL update ptr to (granted+1) mod CHANNELS on each round-robin transfer; ptr SHALL be unchanged in fixed mode or without a transfer.
REQ-026 SHALL apply changes of modo or set to the grant decision of the same cycle; a word already in the output register SHALL not be affected.
REQ-027 SHALL not depend on entrada for channels that are not granted.

Reset
REQ-028 SHALL, while rst_n=0, force the following values asynchronously: saida_valid=0, saidaM=0, saida_canal=0, ptr=0.
REQ-029 SHALL force entrada_ready to all zeros while rst_n=0.
REQ-030 SHALL, on reset mid-stall, discard the held word; no transfer SHALL occur in the first edge after rst_n rises unless valid is presented in that cycle.

Verification
REQ-031 SHALL cover fixed mode:
- Stimulus: modo=0, set=1, all valid, ch0..3 = 0x0001/0x0002/0x0003/0x0004, saida_ready=1.
- Response: saidaM=0x0002, saida_canal=1 one cycle later; entrada_ready=4'b0010.
REQ-032 SHALL cover round-robin:
- Stimulus: modo=1, all four valid, saida_ready=1 for 5 cycles.
- Response: saida_canal sequence is 0,1,2,3,0.
REQ-033 SHALL cover round-robin skip:
- Stimulus: modo=1, ptr=1, only ch3 valid (0xBEEF).
- Response: grant ch3, saidaM=0xBEEF; ptr becomes 0.
REQ-034 SHALL cover backpressure:
- Stimulus: word 0x0003 loaded, saida_ready=0 for 3 cycles while inputs change.
- Response: saidaM stays 0x0003, saida_valid=1, entrada_ready=0; on saida_ready=1, the next word loads in the same edge.
REQ-035 SHALL cover asynchronous reset:
- Stimulus: rst_n pulsed low between clock edges while saida_valid=1.
- Response: immediately saida_valid=0, saidaM=0x0000, saida_canal=0; after release, round-robin restarts at ch0.
REQ-036 SHALL cover out-of-range select:
- Stimulus: CHANNELS=3, modo=0, set=3, all valid.
- Response: entrada_ready=0, saida_valid falls to 0 after the pending word drains.

Source files
------------

// File: rtl/multiplexador_param.sv
// Registered N-channel mux with valid/ready handshakes.
// Fixed-select or round-robin arbitration feeds a one-deep output register.
module multiplexador_param #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] entrada,
  input  logic [CHANNELS-1:0]       entrada_valid,
  output logic [CHANNELS-1:0]       entrada_ready,
  input  logic [SEL_W-1:0]          set,
  input  logic                      modo,
  output logic [WIDTH-1:0]          saidaM,
  output logic                      saida_valid,
  input  logic                      saida_ready,
  output logic [SEL_W-1:0]          saida_canal
);

  logic                load;
  logic                grant;
  logic                hi;
  logic                lo;
  logic [SEL_W-1:0]    hi_i;
  logic [SEL_W-1:0]    lo_i;
  logic [SEL_W-1:0]    gidx;
  logic [SEL_W-1:0]    gnext;
  logic [SEL_W-1:0]    ptr;
  logic [WIDTH-1:0]    gdata;
  logic [CHANNELS-1:0] oh;

  assign load = !saida_valid || saida_ready;

  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    gdata = '0;
    oh    = '0;
    hi    = 1'b0;
    lo    = 1'b0;
    hi_i  = '0;
    lo_i  = '0;
    if (!modo) begin
      // an out-of-range select matches no channel
      for (int i = 0; i < CHANNELS; i++)
        if (set == SEL_W'(i) && entrada_valid[i]) begin
          grant = 1'b1;
          gidx  = SEL_W'(i);
        end
    end else begin
      // lowest valid at/above ptr wins, else wrap to lowest valid
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (entrada_valid[i]) begin
          lo   = 1'b1;
          lo_i = SEL_W'(i);
          if (SEL_W'(i) >= ptr) begin
            hi   = 1'b1;
            hi_i = SEL_W'(i);
          end
        end
      grant = lo;
      gidx  = hi ? hi_i : lo_i;
    end
    for (int i = 0; i < CHANNELS; i++)
      if (gidx == SEL_W'(i)) begin
        gdata = entrada[i*WIDTH +: WIDTH];
        oh[i] = 1'b1;
      end
    gnext = (int'(gidx) == CHANNELS - 1) ? '0 : gidx + SEL_W'(1);
  end

  assign entrada_ready = (rst_n && load && grant) ? oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_valid <= 1'b0;
      saidaM      <= '0;
      saida_canal <= '0;
      ptr         <= '0;
    end else if (load) begin
      if (grant) begin
        saida_valid <= 1'b1;
        saidaM      <= gdata;
        saida_canal <= gidx;
        if (modo)
          ptr <= gnext;
      end else begin
        saida_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiplexador_param.sv
// Directed bench for multiplexador_param.
// Expected words go through a queue and are popped at output time.
module tb_multiplexador_param;

  typedef struct packed {
    logic [1:0]  c;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ent;
  logic [3:0]  ev;
  logic [3:0]  rdy;
  logic [1:0]  set;
  logic        modo;
  logic [15:0] om;
  logic        ov;
  logic        sr;
  logic [1:0]  oc;

  logic [47:0] ent3;
  logic [2:0]  ev3;
  logic [2:0]  rdy3;
  logic [1:0]  set3;
  logic        modo3;
  logic [15:0] om3;
  logic        ov3;
  logic        sr3;
  logic [1:0]  oc3;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  multiplexador_param #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .entrada(ent), .entrada_valid(ev), .entrada_ready(rdy),
    .set(set), .modo(modo),
    .saidaM(om), .saida_valid(ov), .saida_ready(sr),
    .saida_canal(oc)
  );

  multiplexador_param #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .entrada(ent3), .entrada_valid(ev3), .entrada_ready(rdy3),
    .set(set3), .modo(modo3),
    .saidaM(om3), .saida_valid(ov3), .saida_ready(sr3),
    .saida_canal(oc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check ready before the edge, output after it
  task automatic cyc(input string tag, input logic [3:0] xr,
                     input logic push, input logic [1:0] c,
                     input logic [15:0] d);
    exp_t e;
    #1;
    chk({tag, "_rdy"}, 32'(rdy), 32'(xr));
    if (push) q.push_back('{c: c, d: d});
    @(posedge clk);
    #1;
    if (push) begin
      e = q.pop_front();
      chk({tag, "_data"}, 32'(om), 32'(e.d));
      chk({tag, "_canal"}, 32'(oc), 32'(e.c));
      chk({tag, "_valid"}, 32'(ov), 32'(1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ent   = '0;
    ev    = '0;
    set   = '0;
    modo  = 1'b0;
    sr    = 1'b0;
    ent3  = '0;
    ev3   = '0;
    set3  = '0;
    modo3 = 1'b0;
    sr3   = 1'b0;

    #3;
    ent = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    ev  = 4'hf;
    set = 2'd1;
    sr  = 1'b1;
    #1;
    chk("rst_valid", 32'(ov), 32'(0));
    chk("rst_data", 32'(om), 32'(0));
    chk("rst_canal", 32'(oc), 32'(0));
    chk("rst_ready", 32'(rdy), 32'(0));
    ev = '0;
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    ev = 4'hf; modo = 1'b0; set = 2'd1; sr = 1'b1;
    cyc("fix1", 4'b0010, 1'b1, 2'd1, 16'h0002);
    set = 2'd2;
    cyc("fix2", 4'b0100, 1'b1, 2'd2, 16'h0003);
    ev = 4'b1011;
    cyc("fix_nov", 4'b0000, 1'b0, 2'd0, 16'h0);
    chk("drop_valid", 32'(ov), 32'(0));
    chk("drop_data", 32'(om), 32'(16'h0003));
    chk("drop_canal", 32'(oc), 32'(2));

    modo = 1'b1; ev = 4'hf;
    cyc("rr0", 4'b0001, 1'b1, 2'd0, 16'h0001);
    cyc("rr1", 4'b0010, 1'b1, 2'd1, 16'h0002);
    cyc("rr2", 4'b0100, 1'b1, 2'd2, 16'h0003);
    cyc("rr3", 4'b1000, 1'b1, 2'd3, 16'h0004);
    cyc("rr4", 4'b0001, 1'b1, 2'd0, 16'h0001);

    ev = 4'b1000; ent[63:48] = 16'hBEEF;
    cyc("skip", 4'b1000, 1'b1, 2'd3, 16'hBEEF);
    ent[63:48] = 16'h0004; ev = 4'hf;
    cyc("wrap", 4'b0001, 1'b1, 2'd0, 16'h0001);

    modo = 1'b0; set = 2'd2;
    cyc("bp_load", 4'b0100, 1'b1, 2'd2, 16'h0003);
    sr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set = 2'(k);
      ent[15:0] = 16'(k + 16'h10);
      cyc("bp_stall", 4'b0000, 1'b0, 2'd0, 16'h0);
      chk("bp_data", 32'(om), 32'(16'h0003));
      chk("bp_valid", 32'(ov), 32'(1));
      chk("bp_canal", 32'(oc), 32'(2));
    end
    ent[15:0] = 16'h00AA; set = 2'd0; sr = 1'b1;
    cyc("bp_drain", 4'b0001, 1'b1, 2'd0, 16'h00AA);

    sr = 1'b0; modo = 1'b1; ent[15:0] = 16'h0001;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov), 32'(0));
    chk("arst_data", 32'(om), 32'(0));
    chk("arst_canal", 32'(oc), 32'(0));
    chk("arst_ready", 32'(rdy), 32'(0));
    ev = '0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(ov), 32'(0));
    ev = 4'hf; sr = 1'b1;
    cyc("post_rst_rr0", 4'b0001, 1'b1, 2'd0, 16'h0001);
    cyc("post_rst_rr1", 4'b0010, 1'b1, 2'd1, 16'h0002);

    ent3 = {16'h0033, 16'h0022, 16'h0011};
    ev3 = 3'b111; set3 = 2'd2; modo3 = 1'b0; sr3 = 1'b0;
    #1;
    chk("c3_rdy_ch2", 32'(rdy3), 32'(3'b100));
    @(posedge clk);
    #1;
    chk("c3_data", 32'(om3), 32'(16'h0033));
    chk("c3_canal", 32'(oc3), 32'(2));
    chk("c3_valid", 32'(ov3), 32'(1));
    set3 = 2'd3;
    #1;
    chk("c3_oor_rdy_stall", 32'(rdy3), 32'(0));
    @(posedge clk);
    #1;
    chk("c3_oor_hold", 32'(ov3), 32'(1));
    sr3 = 1'b1;
    #1;
    chk("c3_oor_rdy", 32'(rdy3), 32'(0));
    @(posedge clk);
    #1;
    chk("c3_oor_drop", 32'(ov3), 32'(0));
    chk("c3_oor_data", 32'(om3), 32'(16'h0033));

    chk("sb_empty", 32'(q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
